// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DIV_DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring iteration built on a ripple full-adder subtractor.
// Contains the full_adder cell used for the N+1-bit trial subtraction.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next
);
  logic [N:0]   sh;
  logic [N:0]   nd;
  logic [N:0]   t;
  logic [N+1:0] c;
  logic         ge;

  // Shift {A,Q} left by one; the bit leaving A is a[N], folded into ge below.
  assign sh   = {a[N-1:0], q[N-1]};
  assign nd   = ~{1'b0, d};
  assign c[0] = 1'b1;

  for (genvar i = 0; i <= N; i++) begin : g_sub
    full_adder u_fa (
      .a   (sh[i]),
      .b   (nd[i]),
      .cin (c[i]),
      .s   (t[i]),
      .cout(c[i+1])
    );
  end

  // Carry-out means no borrow, i.e. the trial T is non-negative (T[N]==0
  // while A < D holds). a[N] is always 0 in practice but keeps this exact.
  assign ge     = a[N] | c[N+1];
  assign a_next = ge ? t : sh;
  assign q_next = {q[N-2:0], ge};
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with valid/ready on both sides.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's complement operands/results.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N) + 1;

  state_t         state, state_next;
  logic [N:0]     a, a_step;
  logic [N-1:0]   q, q_step, d;
  logic [CW-1:0]  cnt;
  logic           accept, zero_div, last_iter;
  logic [N-1:0]   op_a, op_d, res_q, res_r;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign zero_div  = (divisor == '0);
  assign last_iter = (state == CALC) && (cnt == CW'(N - 1));

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sq, sr;
  // Divide magnitudes, then restore signs: truncation toward zero,
  // remainder follows the dividend. Most-negative magnitude fits unsigned.
  assign op_a  = dividend[N-1] ? -dividend : dividend;
  assign op_d  = divisor[N-1]  ? -divisor  : divisor;
  assign res_q = sq ? -q_step : q_step;
  assign res_r = sr ? -a_step[N-1:0] : a_step[N-1:0];
`else
  assign op_a  = dividend;
  assign op_d  = divisor;
  assign res_q = q_step;
  assign res_r = a_step[N-1:0];
`endif

  div_step #(.N(N)) u_step (
    .a     (a),
    .q     (q),
    .d     (d),
    .a_next(a_step),
    .q_next(q_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = zero_div ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sq          <= 1'b0;
      sr          <= 1'b0;
`endif
    end else if (accept) begin
      a   <= '0;
      q   <= op_a;
      d   <= op_d;
      cnt <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sq  <= dividend[N-1] ^ divisor[N-1];
      sr  <= dividend[N-1];
`endif
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
        out_valid   <= 1'b1;
      end
    end else if (state == CALC) begin
      a   <= a_step;
      q   <= q_step;
      cnt <= cnt + CW'(1);
      if (last_iter) begin
        quotient    <= res_q;
        remainder   <= res_r;
        div_by_zero <= 1'b0;
        out_valid   <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=8): directed vectors, decoupled monitor.
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a result handshake is visible.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
      end
    end
  end

  // Present operands, wait for acceptance, then scramble inputs.
  task automatic accept_op(input logic [7:0] dd, input logic [7:0] dv, input bit push,
                           input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int n = 0;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
    if (push) sbq.push_back('{q: eq, r: er, z: ez});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'hA5;
    divisor  = 8'h00;
  endtask

  // Count cycles until out_valid rises and compare against the expected latency.
  task automatic wait_valid(input int elat);
    int lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency", 32'(lat), 32'(elat));
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic op(input logic [7:0] dd, input logic [7:0] dv,
                    input logic [7:0] eq, input logic [7:0] er, input logic ez, input int elat);
    accept_op(dd, dv, 1'b1, eq, er, ez);
    wait_valid(elat);
    drain();
  endtask

  initial begin
    bit seen;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    op(8'hF9, 8'd2,   8'hFD, 8'hFF, 1'b0, 9);  // -7 / 2
    op(8'd7,  8'hFE,  8'hFD, 8'h01, 1'b0, 9);  // 7 / -2
    op(8'h80, 8'hFF,  8'h80, 8'h00, 1'b0, 9);  // -128 / -1
    op(8'hF9, 8'd0,   8'hFF, 8'hF9, 1'b1, 1);  // -7 / 0
`else
    op(8'd200, 8'd7,  8'd28,  8'd4, 1'b0, 9);
    op(8'd255, 8'd1,  8'd255, 8'd0, 1'b0, 9);
`endif
    op(8'd5,  8'd0,  8'hFF, 8'd5, 1'b1, 1);
    op(8'd9,  8'd3,  8'd3,  8'd0, 1'b0, 9);
    op(8'd3,  8'd10, 8'd0,  8'd3, 1'b0, 9);
    op(8'd7,  8'd7,  8'd1,  8'd0, 1'b0, 9);
    op(8'd0,  8'd5,  8'd0,  8'd0, 1'b0, 9);

    // Result backpressure.
    @(negedge clk);
    out_ready = 1'b0;
    accept_op(8'd100, 8'd9, 1'b1, 8'd11, 8'd1, 1'b0);
    wait_valid(9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_quotient", 32'(quotient), 32'd11);
      chk("bp_remainder", 32'(remainder), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset during the 4th CALC cycle discards the operation.
    accept_op(8'd200, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_quotient", 32'(quotient), 32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    chk("mid_rst_div_by_zero", 32'(div_by_zero), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_partial", 32'(seen), 32'd0);
    op(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
